proto_field_sequencer: RTL

//  Byte-serial protobuf decode controller. Accepts the encoded stream one byte per cycle, parses keys, sequences
//  the varint / 64-bit / length-delimited datapaths and tracks nested embedded messages on a length stack.

---
 rtl/proto_field_sequencer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/proto_field_sequencer.sv
// Byte-serial protobuf decode controller: parses single-byte keys, sequences varint / fixed64 /
// length-delimited fields and tracks nested embedded messages on a stack of end offsets.
module proto_field_sequencer #(
    parameter int MAX_DEPTH = 4,
    parameter int LEN_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic [3:0]  lkp_field_num,
    input  logic        lkp_embedded,
    output logic        fld_valid,
    output logic [3:0]  fld_num,
    output logic [2:0]  fld_wtype,
    output logic [63:0] fld_value,
    output logic        pay_valid,
    output logic [7:0]  pay_data,
    output logic        pay_last,
    output logic        msg_start,
    output logic        msg_end,
    output logic [2:0]  depth,
    output logic        err
);
    localparam int SW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    typedef enum logic [2:0] {KEY, VARINT, FIX64, LEN, PAYLOAD, POP, ERROR} state_t;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] len_acc;
    logic [LEN_W-1:0] stack [MAX_DEPTH];
    logic [63:0]      acc;
    logic [3:0]       idx;
    logic [3:0]       fnum;
    logic             flush;

    logic             fire;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W-1:0] top_end;
    logic [LEN_W-1:0] next_end;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] room;
    logic [2:0]       d_m1;
    logic [SW-1:0]    d_m2;
    logic [6:0]       shamt;
    logic [63:0]      vshift;
    logic [63:0]      fshift;
    logic [63:0]      acc_v;
    logic [63:0]      acc_f;
    logic [127:0]     lshift;
    logic             len_final;
    logic             len_over;
    logic             push;
    logic             push_err;
    logic             field_end;
    logic             bottom_hit;
    logic             last_ok;
    logic             straddle;
    logic             byte_err;
    logic             pop_now;
    logic             to_pop;
    state_t           next_b;

    assign lkp_field_num = fnum;

    always_comb begin
        fire     = s_valid && s_ready;
        cnt_inc  = cnt + 1'b1;
        d_m1     = depth - 3'd1;
        d_m2     = SW'(depth - 3'd2);
        top_end  = stack[d_m1[SW-1:0]];
        shamt    = {3'd0, idx} * 7'd7;
        vshift   = {57'd0, s_data[6:0]} << shamt;
        lshift   = {121'd0, s_data[6:0]} << shamt;
        fshift   = {56'd0, s_data} << {idx[2:0], 3'b000};
        acc_v    = acc | vshift;
        acc_f    = acc | fshift;
        len_next = len_acc | lshift[LEN_W-1:0];
        len_over = (|lshift[127:LEN_W]) || (idx == 4'd10);
        len_final = !s_data[7];
        next_end = cnt_inc + len_next;
        room     = top_end - cnt_inc;
        push     = (state == LEN) && len_final && lkp_embedded;
        // A child message may not extend past the end of the message that contains it.
        push_err = push && ((depth == 3'(MAX_DEPTH)) ||
                            ((depth != 3'd0) && (len_next > room)));

        field_end = 1'b0;
        byte_err  = 1'b0;
        case (state)
            KEY: begin
                byte_err = s_data[7] || (s_data[2:0] > 3'd2);
            end
            VARINT: begin
                field_end = !s_data[7] && (idx != 4'd10);
                byte_err  = (idx == 4'd10);
            end
            FIX64: begin
                field_end = (idx == 4'd7);
            end
            LEN: begin
                field_end = len_final && !len_over && (lkp_embedded || (len_next == '0));
                byte_err  = len_over || push_err;
            end
            PAYLOAD: begin
                field_end = (rem == LEN_W'(1));
            end
            default: begin
                field_end = 1'b0;
                byte_err  = 1'b0;
            end
        endcase

        // Levels are nested, so every open level closes here iff the outermost one does.
        bottom_hit = (depth == 3'd0) || (stack[0] == cnt_inc);
        last_ok    = field_end && (push ? ((len_next == '0) && bottom_hit) : bottom_hit);
        straddle   = (depth != 3'd0) && (cnt_inc == top_end) && !field_end;
        byte_err   = byte_err || straddle || (s_last && !last_ok);
        pop_now    = field_end && (push ? (len_next == '0)
                                        : ((depth != 3'd0) && (top_end == cnt_inc)));
        to_pop     = field_end && (pop_now || (s_last && (push || (depth != 3'd0))));
        next_b     = to_pop ? POP : KEY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= KEY;
            s_ready   <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            len_acc   <= '0;
            acc       <= '0;
            idx       <= '0;
            fnum      <= '0;
            flush     <= 1'b0;
            fld_valid <= 1'b0;
            fld_num   <= '0;
            fld_wtype <= '0;
            fld_value <= '0;
            pay_valid <= 1'b0;
            pay_data  <= '0;
            pay_last  <= 1'b0;
            msg_start <= 1'b0;
            msg_end   <= 1'b0;
            depth     <= '0;
            err       <= 1'b0;
            for (int i = 0; i < MAX_DEPTH; i++) stack[i] <= '0;
        end else begin
            fld_valid <= 1'b0;
            pay_valid <= 1'b0;
            pay_last  <= 1'b0;
            msg_start <= 1'b0;
            msg_end   <= 1'b0;
            case (state)
                ERROR: begin
                    s_ready <= 1'b0;
                end
                POP: begin
                    msg_end <= 1'b1;
                    depth   <= d_m1;
                    if (!((depth > 3'd1) && (flush || (stack[d_m2] == cnt)))) begin
                        state   <= KEY;
                        s_ready <= 1'b1;
                        flush   <= 1'b0;
                    end
                end
                default: begin
                    s_ready <= 1'b1;
                    if (fire && byte_err) begin
                        state   <= ERROR;
                        s_ready <= 1'b0;
                        err     <= 1'b1;
                    end else if (fire) begin
                        cnt <= s_last ? '0 : cnt_inc;
                        if (to_pop) begin
                            s_ready <= 1'b0;
                            flush   <= s_last;
                        end
                        case (state)
                            KEY: begin
                                fnum    <= s_data[6:3];
                                idx     <= '0;
                                acc     <= '0;
                                len_acc <= '0;
                                case (s_data[2:0])
                                    3'd0:    state <= VARINT;
                                    3'd1:    state <= FIX64;
                                    default: state <= LEN;
                                endcase
                            end
                            VARINT: begin
                                acc <= acc_v;
                                idx <= idx + 4'd1;
                                if (field_end) begin
                                    fld_valid <= 1'b1;
                                    fld_num   <= fnum;
                                    fld_wtype <= 3'd0;
                                    fld_value <= acc_v;
                                    state     <= next_b;
                                end
                            end
                            FIX64: begin
                                acc <= acc_f;
                                idx <= idx + 4'd1;
                                if (field_end) begin
                                    fld_valid <= 1'b1;
                                    fld_num   <= fnum;
                                    fld_wtype <= 3'd1;
                                    fld_value <= acc_f;
                                    state     <= next_b;
                                end
                            end
                            LEN: begin
                                len_acc <= len_next;
                                idx     <= idx + 4'd1;
                                if (len_final) begin
                                    if (lkp_embedded) begin
                                        stack[depth[SW-1:0]] <= next_end;
                                        depth     <= depth + 3'd1;
                                        msg_start <= 1'b1;
                                        state     <= next_b;
                                    end else begin
                                        fld_valid <= 1'b1;
                                        fld_num   <= fnum;
                                        fld_wtype <= 3'd2;
                                        fld_value <= 64'(len_next);
                                        rem       <= len_next;
                                        state     <= (len_next == '0) ? next_b : PAYLOAD;
                                    end
                                end
                            end
                            PAYLOAD: begin
                                pay_valid <= 1'b1;
                                pay_data  <= s_data;
                                rem       <= rem - 1'b1;
                                if (field_end) begin
                                    pay_last <= 1'b1;
                                    state    <= next_b;
                                end
                            end
                            default: begin
                                state <= state;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
